shift_ctrl8: RTL and testbench



---
 rtl/shift_ctrl8_if.sv | 24 ++
 rtl/shift_ctrl8.sv | 135 +++++++++++++
 tb/tb_shift_ctrl8.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_ctrl8_if.sv
// Command and shifter-drive bundle for shift_ctrl8.
// The slave modport is the sequencer's view. The master modport is the view of the command source and the shifter.
interface shift_ctrl8_if;
  logic       start;
  logic [1:0] cmd;
  logic [2:0] amount;
  logic [7:0] data;
  logic       ready;
  logic       busy;
  logic       done;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_load;

  modport slave (
    input  start, cmd, amount, data,
    output ready, busy, done, op, shamt, d_load
  );

  modport master (
    output start, cmd, amount, data,
    input  ready, busy, done, op, shamt, d_load
  );
endinterface

// File: rtl/shift_ctrl8.sv
// Command sequencer for the 8-bit shifter: issues LOAD, then greedy steps of at most 3.
// Outputs are decoded from the state, kind, remainder and operand registers.
module shift_ctrl8 (
  input  logic          clk,
  input  logic          reset,
  shift_ctrl8_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_LSL  = 2'b00,
    K_LSR  = 2'b01,
    K_ASR  = 2'b10,
    K_LOAD = 2'b11
  } kind_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100
  } op_t;

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [2:0] rem_q, rem_d;
  logic [7:0] data_q, data_d;

  logic [1:0] step;
  logic [2:0] rem_after;
  op_t        shift_op;

  // Greedy split: a remainder of 3 or more always takes a full step of 3.
  always_comb begin
    step      = (rem_q > 3'd3) ? 2'd3 : rem_q[1:0];
    rem_after = rem_q - {1'b0, step};
  end

  always_comb begin
    shift_op = OP_NOP;
    case (kind_q)
      K_LSL:   shift_op = OP_LSL;
      K_LSR:   shift_op = OP_LSR;
      K_ASR:   shift_op = OP_ASR;
      default: shift_op = OP_NOP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    rem_d   = rem_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          kind_d  = kind_t'(bus.cmd);
          rem_d   = bus.amount;
          data_d  = bus.data;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (kind_q == K_LOAD || rem_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        rem_d = rem_after;
        if (rem_after == 3'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_LSL;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    bus.ready  = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.op     = OP_NOP;
    bus.shamt  = '0;
    bus.d_load = data_q;
    case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
      end
      S_LOAD: begin
        bus.busy = 1'b1;
        bus.op   = OP_LOAD;
      end
      S_SHIFT: begin
        bus.busy  = 1'b1;
        bus.op    = shift_op;
        bus.shamt = step;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.op = OP_NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_ctrl8.sv
// Self-checking bench for shift_ctrl8 with a behavioural shifter downstream.
// Expected results are computed from the command arithmetic, and expected op/shamt sequences from the greedy rule.
module tb_shift_ctrl8;
  logic clk;
  logic reset;
  int unsigned vectors;
  int unsigned miscompares;

  shift_ctrl8_if bus ();

  shift_ctrl8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural downstream shifter; reset leaves it untouched.
  logic [7:0] sh_reg;
  initial sh_reg = 8'h00;
  always @(posedge clk) begin
    case (bus.op)
      3'b001:  sh_reg <= bus.d_load;
      3'b010:  sh_reg <= sh_reg << bus.shamt;
      3'b011:  sh_reg <= sh_reg >> bus.shamt;
      3'b100:  sh_reg <= $signed(sh_reg) >>> bus.shamt;
      default: sh_reg <= sh_reg;
    endcase
  end

  function automatic logic [7:0] model_result(input logic [1:0] c, input logic [2:0] a,
                                              input logic [7:0] d);
    logic [7:0] r;
    case (c)
      2'b00:   r = d << a;
      2'b01:   r = d >> a;
      2'b10:   r = $signed(d) >>> a;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] model_op(input logic [1:0] c);
    case (c)
      2'b00:   return 3'b010;
      2'b01:   return 3'b011;
      default: return 3'b100;
    endcase
  endfunction

  // Issues one command from a negedge and checks every cycle up to DONE, then returns at the first IDLE negedge.
  // With hold set, start stays high after the accept so that a follow-up command (LSR, 3, 8'hFF) is presented throughout.
  task automatic do_cmd(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d,
                        input bit hold);
    logic [2:0] exp_op[$];
    logic [1:0] exp_sh[$];
    int unsigned guard;
    int unsigned cycles;
    int unsigned exp_lat;
    int unsigned r;
    int unsigned s;
    logic [7:0] exp_res;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_wait: ready=%b, required 1 within 20 cycles", bus.ready);
      return;
    end
    bus.start  = 1'b1;
    bus.cmd    = c;
    bus.amount = a;
    bus.data   = d;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      bus.cmd    = 2'b01;
      bus.amount = 3'd3;
      bus.data   = 8'hFF;
    end else begin
      bus.start  = 1'b0;
      bus.cmd    = 2'($urandom);
      bus.amount = 3'($urandom);
      bus.data   = 8'($urandom);
    end
    exp_op.push_back(3'b001);
    exp_sh.push_back(2'd0);
    if (c != 2'b11) begin
      r = a;
      while (r > 0) begin
        s = (r > 3) ? 3 : r;
        exp_op.push_back(model_op(c));
        exp_sh.push_back(2'(s));
        r -= s;
      end
    end
    exp_lat = (c == 2'b11) ? 2 : 2 + (a + 2) / 3;
    exp_res = model_result(c, a, d);
    cycles  = 0;
    while (exp_op.size() > 0) begin
      logic [2:0] eo;
      logic [1:0] es;
      eo = exp_op.pop_front();
      es = exp_sh.pop_front();
      cycles++;
      vectors++;
      if (bus.op !== eo || bus.shamt !== es) begin
        miscompares++;
        $display("FAIL seq_op: cmd=%b amt=%0d cyc=%0d op/shamt=%b/%0d, required %b/%0d",
                 c, a, cycles, bus.op, bus.shamt, eo, es);
      end
      vectors++;
      if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || bus.done !== 1'b0 || bus.d_load !== d) begin
        miscompares++;
        $display("FAIL seq_flags: cyc=%0d busy/ready/done=%b%b%b d_load=%h, required 100 %h",
                 cycles, bus.busy, bus.ready, bus.done, bus.d_load, d);
      end
      @(negedge clk);
    end
    cycles++;
    vectors++;
    if (bus.done !== 1'b1 || bus.op !== 3'b000 || bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_state: done/op/busy/ready=%b/%b/%b/%b, required 1/000/0/0",
               bus.done, bus.op, bus.busy, bus.ready);
    end
    vectors++;
    if (sh_reg !== exp_res) begin
      miscompares++;
      $display("FAIL result: cmd=%b amt=%0d data=%h shifter=%h, required %h",
               c, a, d, sh_reg, exp_res);
    end
    vectors++;
    if (cycles != exp_lat) begin
      miscompares++;
      $display("FAIL latency: cycles=%0d, required %0d", cycles, exp_lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.ready, bus.busy, bus.done, bus.op, bus.shamt, bus.d_load} !== {3'b100, 3'b000, 2'd0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy/busy/done=%b%b%b op=%b shamt=%0d d_load=%h, required 100 000 0 00",
               bus.ready, bus.busy, bus.done, bus.op, bus.shamt, bus.d_load);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_cmd(2'b00, 3'd7, 8'h01, 1'b0);
    do_cmd(2'b10, 3'd5, 8'h90, 1'b0);
    do_cmd(2'b01, 3'd0, 8'hA5, 1'b0);
    do_cmd(2'b11, 3'd6, 8'hA5, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom), 3'($urandom), 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_cmd(2'b00, 3'd7, 8'h01, 1'b1);
    vectors++;
    if (bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle: ready=%b, required 1", bus.ready);
    end
    do_cmd(2'b01, 3'd3, 8'hFF, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.start  = 1'b1;
    bus.cmd    = 2'b00;
    bus.amount = 3'd7;
    bus.data   = 8'h01;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.op !== 3'b000 || bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: op=%b ready=%b busy=%b done=%b, required 000 1 0 0",
               bus.op, bus.ready, bus.busy, bus.done);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_mid_quiet: cyc=%0d done=%b ready=%b, required 0 1", i, bus.done, bus.ready);
      end
    end
    do_cmd(2'b01, 3'd3, 8'h80, 1'b0);
  endtask

  task automatic test_reset_start();
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.cmd    = 2'b00;
    bus.amount = 3'd5;
    bus.data   = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    vectors++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.d_load !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_start: ready=%b busy=%b d_load=%h, required 1 0 00",
               bus.ready, bus.busy, bus.d_load);
    end
    @(negedge clk);
    vectors++;
    if (bus.op !== 3'b000 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_next: op=%b busy=%b, required 000 0", bus.op, bus.busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.cmd     = '0;
    bus.amount  = '0;
    bus.data    = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_reset_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
